// File: rtl/commit_stage_if.sv
// -----------------------------------------------------------------------------
// commit_stage_if
//   ROB commit port as seen by the commit stage: the ROB offers its two oldest
//   entries (slot0 older) and the commit stage answers with rob_ready.
//
//   Signals
//     rob_valid      ROB offers the head pair this cycle
//     rob_ready      commit stage accepts the pair this cycle
//     uop_valid      per-slot entry valid
//     uop_committed  slot already retired on an earlier cycle
//     uop_busy       slot not yet finished by its functional unit
//     uop_wen        slot writes a destination register
//     uop_arch_dst   architectural destination index
//     uop_phys_dst   newly allocated physical destination
//     uop_old_phys   previous physical mapping of arch_dst
//     uop_is_store   slot is a store
//     uop_exc        slot raised an exception
//     uop_mispred    slot is a mispredicted branch
//     uop_target     correct target of a mispredicted branch
//
//   Modports: master = ROB side, slave = commit stage side.
// -----------------------------------------------------------------------------
interface commit_stage_if #(
  parameter int PRF_W = 6
);
  logic                  rob_valid;
  logic                  rob_ready;
  logic [1:0]            uop_valid;
  logic [1:0]            uop_committed;
  logic [1:0]            uop_busy;
  logic [1:0]            uop_wen;
  logic [1:0][4:0]       uop_arch_dst;
  logic [1:0][PRF_W-1:0] uop_phys_dst;
  logic [1:0][PRF_W-1:0] uop_old_phys;
  logic [1:0]            uop_is_store;
  logic [1:0]            uop_exc;
  logic [1:0]            uop_mispred;
  logic [1:0][31:0]      uop_target;

  modport master (
    output rob_valid, uop_valid, uop_committed, uop_busy, uop_wen,
           uop_arch_dst, uop_phys_dst, uop_old_phys, uop_is_store,
           uop_exc, uop_mispred, uop_target,
    input  rob_ready
  );

  modport slave (
    input  rob_valid, uop_valid, uop_committed, uop_busy, uop_wen,
           uop_arch_dst, uop_phys_dst, uop_old_phys, uop_is_store,
           uop_exc, uop_mispred, uop_target,
    output rob_ready
  );
endinterface

// File: rtl/commit_stage.sv
// -----------------------------------------------------------------------------
// commit_stage
//   Consumer end of the ROB commit port. Retires up to two uOPs per cycle from
//   the ROB head pair (slot0 older): writes the architectural RAT, releases the
//   previous physical register to the free list and commits stores. An
//   exception or mispredict on a retiring slot raises a pipeline flush for
//   FLUSH_CYCLES cycles plus a one-cycle fetch redirect.
//
//   Ports
//     clk, rst          clock; synchronous active-high reset
//     rob               commit_stage_if.slave (ROB head pair + rob_ready)
//     arat_we/addr/data ARAT write port per slot (registered, 1-cycle pulses)
//     fl_rel_valid/preg free-list release per slot
//     sb_commit         store-buffer commit strobe per slot
//     flush_req         global flush, high while the FSM is in FLUSH
//     redirect_valid    one-cycle fetch redirect
//     redirect_pc       redirect target
//     perf_commit_cnt   retired uOP count      (COMMIT_PERF_CNT_EN only)
//     perf_flush_cnt    flush event count      (COMMIT_PERF_CNT_EN only)
//
//   Build option: define COMMIT_PERF_CNT_EN to add the two perf counters.
//
//   When both slots write the same ARAT index in one cycle, slot1 is the
//   younger uOP and the ARAT owner must let slot1 win.
// -----------------------------------------------------------------------------
module commit_stage #(
  parameter int          PRF_W        = 6,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic                  clk,
  input  logic                  rst,
  commit_stage_if.slave         rob,
  output logic [1:0]            arat_we,
  output logic [1:0][4:0]       arat_addr,
  output logic [1:0][PRF_W-1:0] arat_data,
  output logic [1:0]            fl_rel_valid,
  output logic [1:0][PRF_W-1:0] fl_rel_preg,
  output logic [1:0]            sb_commit,
  output logic                  flush_req,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [31:0]           perf_commit_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // ---------------------------------------------------------------------------
  // Retire selection
  // ---------------------------------------------------------------------------
  logic        hs;
  logic        done0;
  logic [1:0]  elig;
  logic        ret0, ret1;
  logic        ev0, ev1, evt;
  logic [1:0]  eff;           // slot retires with architectural effects
  logic [31:0] redirect_pc_nxt;

  assign rob.rob_ready = (state == RUN);
  assign hs            = rob.rob_valid & rob.rob_ready;

  // Slot1 may only retire once slot0 is out of the way (absent, already
  // retired, or retiring now) so retirement stays in order.
  assign elig[0] = rob.uop_valid[0] & ~rob.uop_committed[0] & ~rob.uop_busy[0];
  assign done0   = ~rob.uop_valid[0] | rob.uop_committed[0] | elig[0];
  assign elig[1] = rob.uop_valid[1] & ~rob.uop_committed[1] & ~rob.uop_busy[1] & done0;

  assign ret0 = hs & elig[0];
  assign ev0  = ret0 & (rob.uop_exc[0] | rob.uop_mispred[0]);
  // Any slot0 event squashes slot1, which is on the wrong path or after a trap.
  assign ret1 = hs & elig[1] & ~ev0;
  assign ev1  = ret1 & (rob.uop_exc[1] | rob.uop_mispred[1]);
  assign evt  = ev0 | ev1;

  // An excepting uOP leaves no architectural trace; a mispredicted branch
  // itself still retires normally.
  assign eff[0] = ret0 & ~rob.uop_exc[0];
  assign eff[1] = ret1 & ~rob.uop_exc[1];

  // Slot0 wins over slot1; exception wins over mispredict within a slot.
  assign redirect_pc_nxt = ev0 ? (rob.uop_exc[0] ? EXC_VECTOR : rob.uop_target[0])
                               : (rob.uop_exc[1] ? EXC_VECTOR : rob.uop_target[1]);

  // ---------------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first; otherwise a
  // path that leaves it unassigned infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (evt) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt == '0) state_nxt = RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign flush_req = (state == FLUSH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      cnt            <= '0;
      arat_we        <= '0;
      fl_rel_valid   <= '0;
      sb_commit      <= '0;
      redirect_valid <= 1'b0;
      // NOTE: the payload registers are cleared as well, because every output
      // must read zero after reset, not just the strobes.
      arat_addr      <= '0;
      arat_data      <= '0;
      fl_rel_preg    <= '0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      arat_we        <= eff & rob.uop_wen;
      fl_rel_valid   <= eff & rob.uop_wen;
      sb_commit      <= eff & rob.uop_is_store;
      redirect_valid <= evt;
      for (int k = 0; k < 2; k++) begin
        if (eff[k]) begin
          arat_addr[k]   <= rob.uop_arch_dst[k];
          arat_data[k]   <= rob.uop_phys_dst[k];
          fl_rel_preg[k] <= rob.uop_old_phys[k];
        end
      end
      if (evt) redirect_pc <= redirect_pc_nxt;
    end
  end

`ifdef COMMIT_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [1:0] n_ret;
  assign n_ret = {1'b0, eff[0]} + {1'b0, eff[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_commit_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      perf_commit_cnt <= perf_commit_cnt + 32'(n_ret);
      perf_flush_cnt  <= perf_flush_cnt + 32'(evt);
    end
  end
`endif

endmodule

// File: tb/tb_commit_stage.sv
// -----------------------------------------------------------------------------
// tb_commit_stage
//   Self-checking bench for commit_stage. A table of single-cycle vectors is
//   driven through the ROB commit interface; each vector's expectation is
//   pushed to a scoreboard queue when driven and popped one cycle later when
//   the registered outputs appear. Hand-written sequences cover the busy
//   stall, flush length / no handshake during FLUSH, reset mid-FLUSH and the
//   optional perf counters (COMMIT_PERF_CNT_EN).
// -----------------------------------------------------------------------------
module tb_commit_stage;

  localparam int          PRF_W        = 6;
  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;

  logic clk;
  logic rst;

  commit_stage_if #(.PRF_W(PRF_W)) rob_if ();

  logic [1:0]            arat_we;
  logic [1:0][4:0]       arat_addr;
  logic [1:0][PRF_W-1:0] arat_data;
  logic [1:0]            fl_rel_valid;
  logic [1:0][PRF_W-1:0] fl_rel_preg;
  logic [1:0]            sb_commit;
  logic                  flush_req;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
`ifdef COMMIT_PERF_CNT_EN
  logic [31:0]           perf_commit_cnt;
  logic [31:0]           perf_flush_cnt;
`endif

  commit_stage #(
    .PRF_W       (PRF_W),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .EXC_VECTOR  (EXC_VECTOR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rob           (rob_if),
    .arat_we       (arat_we),
    .arat_addr     (arat_addr),
    .arat_data     (arat_data),
    .fl_rel_valid  (fl_rel_valid),
    .fl_rel_preg   (fl_rel_preg),
    .sb_commit     (sb_commit),
    .flush_req     (flush_req),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef COMMIT_PERF_CNT_EN
    ,
    .perf_commit_cnt(perf_commit_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Vector record: inputs for one cycle plus the outputs expected next cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rv;
    logic [1:0]  valid, committed, busy, wen, store, exc, mispred;
    logic [4:0]  a0, a1;
    logic [5:0]  p0, p1, o0, o1;
    logic [31:0] t0, t1;
    logic [1:0]  e_we, e_fl, e_sb;
    logic        e_redir;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[13];
  vec_t exp_q[$];

  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(
    input logic rv,
    input logic [1:0] valid, committed, busy, wen, store, exc, mispred,
    input logic [4:0] a0, a1,
    input logic [5:0] p0, p1, o0, o1,
    input logic [31:0] t0, t1,
    input logic [1:0] e_we, e_fl, e_sb,
    input logic e_redir,
    input logic [31:0] e_pc);
    vec_t v;
    v.rv = rv; v.valid = valid; v.committed = committed; v.busy = busy;
    v.wen = wen; v.store = store; v.exc = exc; v.mispred = mispred;
    v.a0 = a0; v.a1 = a1; v.p0 = p0; v.p1 = p1; v.o0 = o0; v.o1 = o1;
    v.t0 = t0; v.t1 = t1;
    v.e_we = e_we; v.e_fl = e_fl; v.e_sb = e_sb;
    v.e_redir = e_redir; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rob_if.rob_valid     = 1'b0;
    rob_if.uop_valid     = '0;
    rob_if.uop_committed = '0;
    rob_if.uop_busy      = '0;
    rob_if.uop_wen       = '0;
    rob_if.uop_arch_dst  = '0;
    rob_if.uop_phys_dst  = '0;
    rob_if.uop_old_phys  = '0;
    rob_if.uop_is_store  = '0;
    rob_if.uop_exc       = '0;
    rob_if.uop_mispred   = '0;
    rob_if.uop_target    = '0;
  endtask

  // Drive a vector and queue what it must produce one cycle later.
  task automatic drive(input vec_t v);
    rob_if.rob_valid       = v.rv;
    rob_if.uop_valid       = v.valid;
    rob_if.uop_committed   = v.committed;
    rob_if.uop_busy        = v.busy;
    rob_if.uop_wen         = v.wen;
    rob_if.uop_is_store    = v.store;
    rob_if.uop_exc         = v.exc;
    rob_if.uop_mispred     = v.mispred;
    rob_if.uop_arch_dst[0] = v.a0;
    rob_if.uop_arch_dst[1] = v.a1;
    rob_if.uop_phys_dst[0] = v.p0;
    rob_if.uop_phys_dst[1] = v.p1;
    rob_if.uop_old_phys[0] = v.o0;
    rob_if.uop_old_phys[1] = v.o1;
    rob_if.uop_target[0]   = v.t0;
    rob_if.uop_target[1]   = v.t1;
    exp_q.push_back(v);
  endtask

  // Wait for the registered response and compare it with the oldest queued
  // expectation.
  task automatic sample(input string tag);
    vec_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".arat_we"},        32'(arat_we),        32'(e.e_we));
      check({tag, ".fl_rel_valid"},   32'(fl_rel_valid),   32'(e.e_fl));
      check({tag, ".sb_commit"},      32'(sb_commit),      32'(e.e_sb));
      check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(e.e_redir));
      check({tag, ".flush_req"},      32'(flush_req),      32'(e.e_redir));
      check({tag, ".rob_ready"},      32'(rob_if.rob_ready), 32'(!e.e_redir));
      if (e.e_we[0]) begin
        check({tag, ".arat_addr0"}, 32'(arat_addr[0]), 32'(e.a0));
        check({tag, ".arat_data0"}, 32'(arat_data[0]), 32'(e.p0));
      end
      if (e.e_we[1]) begin
        check({tag, ".arat_addr1"}, 32'(arat_addr[1]), 32'(e.a1));
        check({tag, ".arat_data1"}, 32'(arat_data[1]), 32'(e.p1));
      end
      if (e.e_fl[0]) check({tag, ".fl_rel_preg0"}, 32'(fl_rel_preg[0]), 32'(e.o0));
      if (e.e_fl[1]) check({tag, ".fl_rel_preg1"}, 32'(fl_rel_preg[1]), 32'(e.o1));
      if (e.e_redir) check({tag, ".redirect_pc"}, redirect_pc, e.e_pc);
    end
  endtask

  // Called at the negedge where the first FLUSH cycle was observed; counts
  // the FLUSH cycles and confirms nothing retires while flushing.
  task automatic run_flush(input string tag);
    int n;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!flush_req) break;
      n++;
      check({tag, ".ready_in_flush"}, 32'(rob_if.rob_ready), 32'd0);
      check({tag, ".we_in_flush"},    32'(arat_we),          32'd0);
      check({tag, ".redir_pulse"},    32'(redirect_valid),   32'd0);
    end
    check({tag, ".flush_len"},      32'(n),                FLUSH_CYCLES);
    check({tag, ".ready_after"},    32'(rob_if.rob_ready), 32'd1);
    check({tag, ".we_after_flush"}, 32'(arat_we),          32'd0);
    idle_inputs();
  endtask

  // Slot0 mispredict with slot1 eligible; ROB keeps offering during FLUSH.
  task automatic run_mispred(input string tag);
    drive(mk(1'b1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01,
             5'd1, 5'd9, 6'd30, 6'd31, 6'd2, 6'd3, 32'h8000_1000, 32'h0,
             2'b01, 2'b01, 2'b00, 1'b1, 32'h8000_1000));
    sample(tag);
    run_flush(tag);
  endtask

  initial begin
    // Reset outputs/ready first is slot0 column, then slot1 (bit1 = slot1).
    vecs[0]  = mk(1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 5'd3, 5'd4, 6'd10, 6'd11, 6'd5,  6'd6,  32'h0, 32'h0,         2'b11, 2'b11, 2'b00, 0, 32'h0);
    vecs[1]  = mk(1, 2'b11, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 5'd8, 5'd9, 6'd12, 6'd13, 6'd14, 6'd15, 32'h0, 32'h0,         2'b00, 2'b00, 2'b10, 0, 32'h0);
    vecs[2]  = mk(1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 5'd7, 5'd7, 6'd20, 6'd21, 6'd22, 6'd23, 32'h0, 32'h0,         2'b11, 2'b11, 2'b00, 0, 32'h0);
    vecs[3]  = mk(1, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 5'd1, 5'd2, 6'd24, 6'd25, 6'd26, 6'd27, 32'h0, 32'h0,         2'b10, 2'b10, 2'b00, 0, 32'h0);
    vecs[4]  = mk(1, 2'b11, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 5'd0, 5'd0, 6'd0,  6'd0,  6'd0,  6'd0,  32'h0, 32'h0,         2'b00, 2'b00, 2'b01, 0, 32'h0);
    vecs[5]  = mk(0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 5'd3, 5'd4, 6'd10, 6'd11, 6'd5,  6'd6,  32'h0, 32'h0,         2'b00, 2'b00, 2'b00, 0, 32'h0);
    vecs[6]  = mk(1, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 5'd3, 5'd4, 6'd10, 6'd11, 6'd5,  6'd6,  32'h0, 32'h0,         2'b00, 2'b00, 2'b00, 0, 32'h0);
    vecs[7]  = mk(1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 5'd5, 5'd6, 6'd30, 6'd31, 6'd32, 6'd33, 32'h0, 32'h0,         2'b01, 2'b01, 2'b00, 1, 32'hBFC0_0380);
    vecs[8]  = mk(1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 5'd0, 5'd12, 6'd0, 6'd40, 6'd0,  6'd41, 32'h0, 32'h1234_5678, 2'b10, 2'b10, 2'b01, 1, 32'h1234_5678);
    vecs[9]  = mk(1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 5'd2, 5'd3, 6'd42, 6'd43, 6'd44, 6'd45, 32'hDEAD_0000, 32'h0, 2'b00, 2'b00, 2'b00, 1, 32'hBFC0_0380);
    vecs[10] = mk(1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 5'd4, 5'd5, 6'd46, 6'd47, 6'd48, 6'd49, 32'h4000_0040, 32'h0, 2'b01, 2'b01, 2'b00, 1, 32'h4000_0040);
    vecs[11] = mk(1, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 5'd10, 5'd11, 6'd50, 6'd51, 6'd52, 6'd53, 32'h0, 32'h0,      2'b01, 2'b01, 2'b00, 0, 32'h0);
    vecs[12] = mk(1, 2'b11, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 5'd13, 5'd14, 6'd54, 6'd55, 6'd56, 6'd57, 32'h0, 32'h0,      2'b10, 2'b10, 2'b00, 0, 32'h0);

    // Reset state.
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset.arat_we",        32'(arat_we),          32'd0);
    check("reset.fl_rel_valid",   32'(fl_rel_valid),     32'd0);
    check("reset.sb_commit",      32'(sb_commit),        32'd0);
    check("reset.flush_req",      32'(flush_req),        32'd0);
    check("reset.redirect_valid", 32'(redirect_valid),   32'd0);
    check("reset.redirect_pc",    redirect_pc,           32'd0);
    check("reset.rob_ready",      32'(rob_if.rob_ready), 32'd1);
    rst = 1'b0;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      sample($sformatf("vec%0d", i));
      idle_inputs();
      if (vecs[i].e_redir) run_flush($sformatf("vec%0d", i));
    end

    // Slot0 busy stalls both slots; once it finishes both retire together.
    drive(mk(1, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 5'd3, 5'd4, 6'd10, 6'd11, 6'd5, 6'd6,
             32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 0, 32'h0));
    sample("busy.stall");
    drive(mk(1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 5'd3, 5'd4, 6'd10, 6'd11, 6'd5, 6'd6,
             32'h0, 32'h0, 2'b11, 2'b11, 2'b00, 0, 32'h0));
    sample("busy.release");
    idle_inputs();

    // Mispredict, flush length and no handshake while flushing.
    run_mispred("mispred");

    // Exception on slot0, then reset one cycle into FLUSH.
    drive(mk(1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 5'd2, 5'd6, 6'd40, 6'd41, 6'd42, 6'd43,
             32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 1, 32'hBFC0_0380));
    sample("exc");
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_flush.flush_req",      32'(flush_req),        32'd0);
    check("rst_flush.redirect_valid", 32'(redirect_valid),   32'd0);
    check("rst_flush.redirect_pc",    redirect_pc,           32'd0);
    check("rst_flush.rob_ready",      32'(rob_if.rob_ready), 32'd1);
    check("rst_flush.arat_we",        32'(arat_we),          32'd0);
    check("rst_flush.fl_rel_valid",   32'(fl_rel_valid),     32'd0);
    check("rst_flush.sb_commit",      32'(sb_commit),        32'd0);
    @(negedge clk);
    check("rst_flush.stays_run",      32'(flush_req),        32'd0);

`ifdef COMMIT_PERF_CNT_EN
    check("perf.reset_commit", perf_commit_cnt, 32'd0);
    check("perf.reset_flush",  perf_flush_cnt,  32'd0);
    drive(vecs[0]);
    sample("perf.t1");
    idle_inputs();
    drive(vecs[1]);
    sample("perf.t3");
    idle_inputs();
    run_mispred("perf.t4");
    check("perf.commit_cnt", perf_commit_cnt, 32'd4);
    check("perf.flush_cnt",  perf_flush_cnt,  32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
